// File: rtl/proc_mem_pipe.sv
// proc_mem_pipe: dual-port (instruction read / data read-write) word memory
// with a LAT-deep response pipeline per port and access-fault detection.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imemreq_val/rdy/addr          instruction read request
//   imemresp_val/data/err         instruction response
//   dmemreq_val/rdy/type/addr     data request (type 0 = read, 1 = write)
//   dmemreq_wdata/wstrb           write data and byte enables
//   dmemresp_val/rdata/err        data response
module proc_mem_pipe #(
   parameter int NWORDS = 64,
   parameter int LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemreq_val,
   output logic        imemreq_rdy,
   input  logic [31:0] imemreq_addr,
   output logic        imemresp_val,
   output logic [31:0] imemresp_data,
   output logic        imemresp_err,
   input  logic        dmemreq_val,
   output logic        dmemreq_rdy,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   input  logic [3:0]  dmemreq_wstrb,
   output logic        dmemresp_val,
   output logic [31:0] dmemresp_rdata,
   output logic        dmemresp_err
);

   localparam int AW = $clog2(NWORDS);

   logic [31:0] mem [NWORDS];

   logic [31:0] ip_data [LAT];
   logic        ip_val  [LAT];
   logic        ip_err  [LAT];
   logic [31:0] dp_data [LAT];
   logic        dp_val  [LAT];
   logic        dp_err  [LAT];

   logic          i_acc;
   logic          d_acc;
   logic          i_fault;
   logic          d_fault;
   logic [AW-1:0] i_idx;
   logic [AW-1:0] d_idx;

   assign imemreq_rdy = !rst;
   assign dmemreq_rdy = !rst;

   assign i_acc = imemreq_val && imemreq_rdy;
   assign d_acc = dmemreq_val && dmemreq_rdy;

   assign i_idx = imemreq_addr[AW+1:2];
   assign d_idx = dmemreq_addr[AW+1:2];

   // Misaligned or beyond the array: the upper bits must all be zero,
   // otherwise the address would silently alias onto a low word.
   assign i_fault = (imemreq_addr[1:0] != 2'b00) ||
                    (imemreq_addr[31:AW+2] != '0);
   assign d_fault = (dmemreq_addr[1:0] != 2'b00) ||
                    (dmemreq_addr[31:AW+2] != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < NWORDS; w++) begin
            mem[w] <= '0;
         end
         for (int s = 0; s < LAT; s++) begin
            ip_val[s]  <= 1'b0;
            ip_err[s]  <= 1'b0;
            ip_data[s] <= '0;
            dp_val[s]  <= 1'b0;
            dp_err[s]  <= 1'b0;
            dp_data[s] <= '0;
         end
      end else begin
         // Reads below see the pre-edge array: no write bypass.
         ip_val[0]  <= i_acc;
         ip_err[0]  <= i_acc && i_fault;
         ip_data[0] <= (i_acc && !i_fault) ? mem[i_idx] : '0;

         dp_val[0]  <= d_acc;
         dp_err[0]  <= d_acc && d_fault;
         dp_data[0] <= (d_acc && !d_fault && !dmemreq_type)
                       ? mem[d_idx] : '0;

         if (d_acc && dmemreq_type && !d_fault) begin
            for (int b = 0; b < 4; b++) begin
               if (dmemreq_wstrb[b]) begin
                  mem[d_idx][8*b +: 8] <= dmemreq_wdata[8*b +: 8];
               end
            end
         end

         for (int s = 1; s < LAT; s++) begin
            ip_val[s]  <= ip_val[s-1];
            ip_err[s]  <= ip_err[s-1];
            ip_data[s] <= ip_data[s-1];
            dp_val[s]  <= dp_val[s-1];
            dp_err[s]  <= dp_err[s-1];
            dp_data[s] <= dp_data[s-1];
         end
      end
   end

   // Stage data/err are only nonzero alongside valid, so the
   // outputs stay zero whenever no response is presented.
   assign imemresp_val   = ip_val[LAT-1];
   assign imemresp_data  = ip_data[LAT-1];
   assign imemresp_err   = ip_err[LAT-1];
   assign dmemresp_val   = dp_val[LAT-1];
   assign dmemresp_rdata = dp_data[LAT-1];
   assign dmemresp_err   = dp_err[LAT-1];

endmodule

// File: tb/tb_proc_mem_pipe.sv
// tb_proc_mem_pipe: directed stimulus into two proc_mem_pipe instances
// (LAT=2 and LAT=3) sharing inputs, checked against a queue scoreboard.
module tb_proc_mem_pipe;

   localparam int NW = 64;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemreq_val;
   logic [31:0] imemreq_addr;
   logic        dmemreq_val;
   logic        dmemreq_type;
   logic [31:0] dmemreq_addr;
   logic [31:0] dmemreq_wdata;
   logic [3:0]  dmemreq_wstrb;

   logic        a_irdy, a_iv, a_ie, a_drdy, a_dv, a_de;
   logic [31:0] a_id, a_dd;
   logic        b_irdy, b_iv, b_ie, b_drdy, b_dv, b_de;
   logic [31:0] b_id, b_dd;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t qai[$];
   exp_t qad[$];
   exp_t qbi[$];
   exp_t qbd[$];

   logic [31:0] mdl [NW];

   proc_mem_pipe #(.NWORDS(NW), .LAT(2)) u_a (
      .clk(clk), .rst(rst),
      .imemreq_val(imemreq_val), .imemreq_rdy(a_irdy),
      .imemreq_addr(imemreq_addr),
      .imemresp_val(a_iv), .imemresp_data(a_id), .imemresp_err(a_ie),
      .dmemreq_val(dmemreq_val), .dmemreq_rdy(a_drdy),
      .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
      .dmemreq_wdata(dmemreq_wdata), .dmemreq_wstrb(dmemreq_wstrb),
      .dmemresp_val(a_dv), .dmemresp_rdata(a_dd), .dmemresp_err(a_de)
   );

   proc_mem_pipe #(.NWORDS(NW), .LAT(3)) u_b (
      .clk(clk), .rst(rst),
      .imemreq_val(imemreq_val), .imemreq_rdy(b_irdy),
      .imemreq_addr(imemreq_addr),
      .imemresp_val(b_iv), .imemresp_data(b_id), .imemresp_err(b_ie),
      .dmemreq_val(dmemreq_val), .dmemreq_rdy(b_drdy),
      .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
      .dmemreq_wdata(dmemreq_wdata), .dmemreq_wstrb(dmemreq_wstrb),
      .dmemresp_val(b_dv), .dmemresp_rdata(b_dd), .dmemresp_err(b_de)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic is_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
   endfunction

   task automatic chk(input string tag, input int lat, input logic v,
                      input logic [31:0] d, input logic e,
                      input int qn, input exp_t x);
      if (v) begin
         total++;
         assert (qn > 0) else begin
            bad++;
            $error("FAIL %s.unexpected got val=1 want no response", tag);
         end
         if (qn > 0) begin
            total++;
            assert (d === x.data) else begin
               bad++;
               $error("FAIL %s.data got %h want %h", tag, d, x.data);
            end
            total++;
            assert (e === x.err) else begin
               bad++;
               $error("FAIL %s.err got %b want %b", tag, e, x.err);
            end
            total++;
            assert (cyc === x.acc + lat - 1) else begin
               bad++;
               $error("FAIL %s.timing got edge %0d want %0d",
                      tag, cyc, x.acc + lat - 1);
            end
         end
      end else begin
         total++;
         assert (d === 32'd0 && e === 1'b0) else begin
            bad++;
            $error("FAIL %s.idle got data=%h err=%b want 0/0", tag, d, e);
         end
      end
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      x = '0;
      if (qai.size() > 0) x = qai[0];
      chk("a.imem", 2, a_iv, a_id, a_ie, qai.size(), x);
      if (a_iv && qai.size() > 0) void'(qai.pop_front());
      x = '0;
      if (qad.size() > 0) x = qad[0];
      chk("a.dmem", 2, a_dv, a_dd, a_de, qad.size(), x);
      if (a_dv && qad.size() > 0) void'(qad.pop_front());
      x = '0;
      if (qbi.size() > 0) x = qbi[0];
      chk("b.imem", 3, b_iv, b_id, b_ie, qbi.size(), x);
      if (b_iv && qbi.size() > 0) void'(qbi.pop_front());
      x = '0;
      if (qbd.size() > 0) x = qbd[0];
      chk("b.dmem", 3, b_dv, b_dd, b_de, qbd.size(), x);
      if (b_dv && qbd.size() > 0) void'(qbd.pop_front());
   end

   // Called at a negedge; the following posedge is the accept edge.
   task automatic drive(input logic iv, input logic [31:0] ia,
                        input logic dv, input logic dt,
                        input logic [31:0] da, input logic [31:0] wd,
                        input logic [3:0] ws);
      exp_t x;
      imemreq_val   = iv;
      imemreq_addr  = ia;
      dmemreq_val   = dv;
      dmemreq_type  = dt;
      dmemreq_addr  = da;
      dmemreq_wdata = wd;
      dmemreq_wstrb = ws;
      if (iv) begin
         x.acc  = cyc + 1;
         x.err  = is_fault(ia);
         x.data = x.err ? 32'd0 : mdl[ia[7:2]];
         qai.push_back(x);
         qbi.push_back(x);
      end
      if (dv) begin
         x.acc  = cyc + 1;
         x.err  = is_fault(da);
         x.data = (x.err || dt) ? 32'd0 : mdl[da[7:2]];
         qad.push_back(x);
         qbd.push_back(x);
         if (dt && !x.err) begin
            for (int b = 0; b < 4; b++) begin
               if (ws[b]) mdl[da[7:2]][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      imemreq_val = 1'b0;
      dmemreq_val = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic rdir(input logic [31:0] a);
      drive(1'b0, 32'd0, 1'b1, 1'b0, a, 32'd0, 4'd0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      drive(1'b0, 32'd0, 1'b1, 1'b1, a, d, s);
   endtask

   task automatic chk_rst_outs(input string tag);
      total++;
      assert ({a_irdy, a_drdy, b_irdy, b_drdy} === 4'd0) else begin
         bad++;
         $error("FAIL %s.rdy got %b want 0000", tag,
                {a_irdy, a_drdy, b_irdy, b_drdy});
      end
      total++;
      assert ({a_iv, a_ie, a_dv, a_de, b_iv, b_ie, b_dv, b_de} === 8'd0 &&
              (a_id | a_dd | b_id | b_dd) === 32'd0) else begin
         bad++;
         $error("FAIL %s.outs got nonzero response outputs want 0", tag);
      end
   endtask

   initial begin
      rst = 1'b1;
      imemreq_val = 1'b0;
      imemreq_addr = '0;
      dmemreq_val = 1'b0;
      dmemreq_type = 1'b0;
      dmemreq_addr = '0;
      dmemreq_wdata = '0;
      dmemreq_wstrb = '0;
      for (int w = 0; w < NW; w++) mdl[w] = '0;

      repeat (3) @(negedge clk);
      chk_rst_outs("reset");
      rst = 1'b0;
      #1;
      total++;
      assert ({a_irdy, a_drdy, b_irdy, b_drdy} === 4'hF) else begin
         bad++;
         $error("FAIL rdy_after_reset got %b want 1111",
                {a_irdy, a_drdy, b_irdy, b_drdy});
      end
      @(negedge clk);
      rst = 1'b0;

      // Write/read round trip, issued in the first cycle out of reset.
      wr(32'h10, 32'hDEADBEEF, 4'hF);
      rdir(32'h10);
      idle(1);

      // Byte strobes.
      wr(32'h20, 32'h11223344, 4'hF);
      wr(32'h20, 32'hAABBCCDD, 4'b0101);
      rdir(32'h20);
      idle(4);

      // Faults: out-of-range and misaligned on both ports.
      rdir(32'h100);
      rdir(32'h06);
      wr(32'h100, 32'hFFFFFFFF, 4'hF);
      drive(1'b1, 32'h103, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h81, 32'h12345678, 4'hF);
      idle(1);

      // Same-edge imem read / dmem write to one word.
      drive(1'b1, 32'h08, 1'b1, 1'b1, 32'h08, 32'h55, 4'hF);
      drive(1'b1, 32'h08, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      idle(4);

      // Streaming imem reads alongside dmem writes.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(i * 4), 1'b1, 1'b1, 32'(32'h40 + i * 4),
               32'($urandom), 4'($urandom_range(0, 15)));
      end
      idle(1);

      // Full readback: any aliasing or stray write shows up here.
      for (int w = 0; w < NW; w++) begin
         drive(1'b1, 32'((NW - 1 - w) * 4), 1'b1, 1'b0, 32'(w * 4),
               32'd0, 4'd0);
      end
      idle(5);

      // Reset with requests in flight: nothing may come out.
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
      rst = 1'b1;
      imemreq_val = 1'b0;
      dmemreq_val = 1'b0;
      qai.delete();
      qad.delete();
      qbi.delete();
      qbd.delete();
      for (int w = 0; w < NW; w++) mdl[w] = '0;
      @(negedge clk);
      chk_rst_outs("midreset");
      @(negedge clk);
      rst = 1'b0;
      idle(4);
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
      drive(1'b1, 32'h08, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
      idle(1);

      for (int i = 0; i < 40; i++) begin
         if (qai.size() + qad.size() + qbi.size() + qbd.size() == 0) break;
         @(negedge clk);
      end
      total++;
      assert (qai.size() + qad.size() + qbi.size() + qbd.size() == 0)
      else begin
         bad++;
         $error("FAIL drain got %0d/%0d/%0d/%0d pending want 0",
                qai.size(), qad.size(), qbi.size(), qbd.size());
      end
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/proc_mem_pipe.md
PROC_MEM_PIPE -- requirements
Module: proc_mem_pipe

Interface
REQ-001 SHALL have parameter NWORDS, default 64, number of 32-bit words; power of two, 16..4096.
REQ-002 SHALL have parameter LAT, default 1, response latency in cycles; legal 1..4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imemreq_val  input  1  instruction read request valid.
REQ-006 SHALL have port imemreq_rdy  output  1  instruction request accept.
REQ-007 SHALL have port imemreq_addr  input  32  instruction byte address.
REQ-008 SHALL have port imemresp_val  output  1  instruction response valid.
REQ-009 SHALL have port imemresp_data  output  32  instruction word.
REQ-010 SHALL have port imemresp_err  output  1  instruction access fault.
REQ-011 SHALL have port dmemreq_val  input  1  data request valid.
REQ-012 SHALL have port dmemreq_rdy  output  1  data request accept.
REQ-013 SHALL have port dmemreq_type  input  1  0 = read, 1 = write.
REQ-014 SHALL have port dmemreq_addr  input  32  data byte address.
REQ-015 SHALL have port dmemreq_wdata  input  32  write data.
REQ-016 SHALL have port dmemreq_wstrb  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-017 SHALL have port dmemresp_val  output  1  data response valid.
REQ-018 SHALL have port dmemresp_rdata  output  32  read data.
REQ-019 SHALL have port dmemresp_err  output  1  data access fault.

Function
REQ-020 SHALL drive imemreq_rdy and dmemreq_rdy as !rst; accept occurs on an edge where val && rdy.
REQ-021 SHALL form the word index as addr[log2(NWORDS)+1:2].
REQ-022 SHALL flag a fault when addr[1:0] != 0 or addr[31:log2(NWORDS)+2] != 0.
REQ-023 SHALL, for a non-faulting accepted write, update only the bytes with wstrb set, at the accept edge.
REQ-024 SHALL leave memory unchanged for a faulting write or for wstrb = 0.
REQ-025 SHALL sample read data from the array value before any same-edge write; imem and dmem read paths are independent.
REQ-026 SHALL carry each accepted request through a LAT-stage valid/data/err pipeline per port.
REQ-027 SHALL assert resp_val for exactly one cycle, starting LAT cycles after the accept edge.
REQ-028 SHALL sustain one accept per port per cycle, giving back-to-back responses in order.
REQ-029 SHALL return dmemresp_rdata = 0 for writes.
REQ-030 SHALL return resp_data/rdata = 0 with resp_err = 1 for faulting requests.
REQ-031 SHALL drive resp_data/rdata = 0 and resp_err = 0 whenever resp_val = 0.
REQ-032 SHALL make a write at edge N visible to a read accepted at edge N+1 or later, on either port.
REQ-033 SHALL not bypass on same-edge imem read / dmem write to the same word; the read returns old data.

Reset
REQ-034 SHALL, while rst is high, zero all NWORDS words, clear all pipeline valids, and deassert both rdy signals.
REQ-035 SHALL drop in-flight requests on rst; no resp_val in the cycle after rst deasserts.
REQ-036 SHALL drive every output 0 during reset, except rdy, which is 0 per REQ-034.
REQ-037 SHALL accept requests in the first cycle after rst deasserts.

Verification
REQ-038 SHALL check write/read: LAT=2; write 0xDEADBEEF to 0x10 with wstrb=F, then dmem read 0x10 -> dmemresp_val two cycles later, rdata=0xDEADBEEF, err=0.
REQ-039 SHALL check byte strobes: word at 0x20 is 0x11223344; write 0xAABBCCDD with wstrb=0101 -> read returns 0x11BB33DD.
REQ-040 SHALL check faults: NWORDS=64; read 0x100 and read 0x06 -> each returns err=1, rdata=0; write to 0x100 leaves all words unchanged.
REQ-041 SHALL check same-edge conflict: imem read 0x08 with dmem write 0x55 to 0x08 on the same edge -> imem data old (0); imem read next cycle -> 0x55.
REQ-042 SHALL check streaming: LAT=3; 8 back-to-back imem reads 0x00..0x1C -> 8 consecutive resp_val cycles, in order, starting 3 cycles after the first accept.
REQ-043 SHALL check reset mid-flight: assert rst one cycle after a read accept -> no response emitted; memory reads 0 after reset.
